// File: rtl/serial_config_master.sv
// Serial config master: turns parallel register commands into enable/clock/data
// frames (8-bit address then 32-bit data, MSB first) and captures read data from SDO.
module serial_config_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        serial_clock,
  output logic        serial_data,
  output logic        serial_enable,
  input  logic        serial_data_in
);

  localparam int unsigned PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAME_W = ADDR_W + DATA_W;

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                high_q, high_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                read_q, read_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                busy_q, busy_d;
  logic                sclk_q, sclk_d;
  logic                sdat_q, sdat_d;
  logic                sen_q, sen_d;

  logic                accept;
  logic                phase_last;
  logic [FRAME_W-1:0]  frame;

  assign cmd_ready = (state_q == IDLE) && reset_n;

  // Next-state, counters, capture and registered-output values
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    high_d      = high_q;
    bit_d       = bit_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_d      = read_q;
    cap_d       = cap_q;
    rsp_rdata_d = rsp_rdata_q;

    accept     = cmd_valid && cmd_ready;
    phase_last = (phase_q == PH_LAST);
    frame      = {addr_q, (read_q ? {DATA_W{1'b0}} : wdata_q)};

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          phase_d = '0;
          high_d  = 1'b0;
          bit_d   = BIT_FIRST;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          read_d  = cmd_addr[ADDR_W-1];
        end
      end
      SETUP: begin
        if (phase_last) begin
          state_d = SHIFT;
          phase_d = '0;
          high_d  = 1'b0;
        end else begin
          phase_d = PH_W'(phase_q + 1'b1);
        end
      end
      SHIFT: begin
        if (phase_last) begin
          phase_d = '0;
          high_d  = !high_q;
          if (high_q) begin
            if (bit_q == '0) begin
              state_d = HOLD;
            end else begin
              bit_d = BIT_W'(bit_q - 1'b1);
            end
          end
        end else begin
          phase_d = PH_W'(phase_q + 1'b1);
        end
      end
      HOLD: begin
        if (phase_last) begin
          state_d = GAP;
          phase_d = '0;
        end else begin
          phase_d = PH_W'(phase_q + 1'b1);
        end
      end
      GAP: begin
        if (phase_last) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = PH_W'(phase_q + 1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Sample SDO on the edge that raises serial_clock for a data bit
    if ((state_q == SHIFT) && !high_q && phase_last && read_q && (bit_q < DATA_BITS)) begin
      cap_d = {cap_q[DATA_W-2:0], serial_data_in};
    end

    // Outputs are registered from the next-state view so they line up with the state
    rsp_valid_d = (state_d == GAP) && (phase_d == PH_LAST);
    if (rsp_valid_d) begin
      rsp_rdata_d = read_q ? cap_d : {DATA_W{1'b0}};
    end
    busy_d = (state_d != IDLE);
    sen_d  = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
    sclk_d = (state_d == SHIFT) && high_d;
    sdat_d = (state_d == SHIFT) && frame[bit_d];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      high_q      <= 1'b0;
      bit_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sdat_q      <= 1'b0;
      sen_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      high_q      <= high_d;
      bit_q       <= bit_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_q      <= read_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      sen_q       <= sen_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = busy_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdat_q;
  assign serial_enable = sen_q;

endmodule
